// File: rtl/ifetch_seq.sv
// Byte-serial instruction fetch: assembles four big-endian bytes into a word,
// holds it until a valid/ready handshake, and supports redirects and address faults.
module ifetch_seq #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [1:0]  dbg_state
);

  // Handshake: a word transfers on any rising edge where instr_valid and
  // instr_ready are both high; instr/instr_pc are stable while valid waits.
  localparam logic [1:0]  S_FETCH   = 2'd0;
  localparam logic [1:0]  S_HOLD    = 2'd1;
  localparam logic [1:0]  S_FAULT   = 2'd2;
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_cnt;
  logic [31:0] r_shift;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;

  logic        w_redir_ok;
  logic        w_handshake;
  logic [31:0] w_byte_addr;
  logic [31:0] w_word;

  assign w_redir_ok  = (redirect_pc[1:0] == 2'b00) && (redirect_pc < MEM_LIMIT);
  assign w_handshake = (r_state == S_HOLD) && r_instr_valid && instr_ready;
  assign w_byte_addr = r_pc + {30'd0, r_cnt};
  // The last byte arrives combinationally, so the full word is the shift
  // register's upper three bytes plus the current memory byte.
  assign w_word      = {r_shift[31:8], mem_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_cnt         <= 2'd0;
      r_shift       <= 32'd0;
      r_instr       <= 32'd0;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
    end else if (redirect) begin
      r_state       <= w_redir_ok ? S_FETCH : S_FAULT;
      r_pc          <= redirect_pc;
      r_cnt         <= 2'd0;
      r_shift       <= 32'd0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          case (r_cnt)
            2'd0:    r_shift[31:24] <= mem_data;
            2'd1:    r_shift[23:16] <= mem_data;
            2'd2:    r_shift[15:8]  <= mem_data;
            default: r_shift[7:0]   <= mem_data;
          endcase
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state       <= S_HOLD;
            r_instr       <= w_word;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_handshake) begin
            r_state       <= S_FETCH;
            r_pc          <= (r_pc + 32'd4) & ADDR_MASK;
            r_cnt         <= 2'd0;
            r_instr_valid <= 1'b0;
          end
        end
        S_FAULT: begin
          r_cnt <= 2'd0;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign mem_rd      = (r_state == S_FETCH) && !rst;
  assign mem_addr    = (r_state == S_FETCH) ? w_byte_addr : r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fault       = (r_state == S_FAULT);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: byte memory model, one task per scenario,
// inline comparisons against hand-computed words and addresses.
module tb_ifetch_seq;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:4095];
  logic [31:0] exp_q[$];

  ifetch_seq #(.RESET_PC(32'h0), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fault(fault), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_data = 8'h00;
    if (mem_addr < 32'd4096) mem_data = mem[mem_addr[11:0]];
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Walks one four-byte fetch starting at addr and checks the assembled word.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] word);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem_rd !== 1'b1 || mem_addr !== addr + 32'(k)) begin
        n_fail++;
        $display("FAIL fetch_addr: got rd=%b addr=%h expected rd=1 addr=%h", mem_rd, mem_addr, addr + 32'(k));
      end
      tick();
    end
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== word || instr_pc !== addr || mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_word: got v=%b instr=%h pc=%h rd=%b expected v=1 instr=%h pc=%h rd=0",
               instr_valid, instr, instr_pc, mem_rd, word, addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    n_checks++;
    if (instr_valid !== 1'b0 || fault !== 1'b0 || mem_rd !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b f=%b rd=%b instr=%h pc=%h expected 0 0 0 0 0",
               instr_valid, fault, mem_rd, instr, instr_pc);
    end
    rst = 1'b0; instr_ready = 1'b1;
    #1;
    run_fetch(32'h0, 32'h00A00513);
    instr_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00A00513 || mem_rd !== 1'b0 || mem_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b instr=%h rd=%b addr=%h expected v=1 instr=00a00513 rd=0 addr=0",
                 instr_valid, instr, mem_rd, mem_addr);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'h4 || mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got v=%b addr=%h rd=%b expected v=0 addr=4 rd=1", instr_valid, mem_addr, mem_rd);
    end
    run_fetch(32'h4, 32'h11223344);
  endtask

  task automatic test_redirect_partial();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (mem_addr !== 32'ha) begin
      n_fail++;
      $display("FAIL partial_addr: got %h expected 0000000a", mem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_valid: got v=%b f=%b expected v=0 f=0", instr_valid, fault);
    end
    run_fetch(32'h40, 32'hDEADBEEF);
  endtask

  task automatic test_redirect_handshake();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    instr_ready = 1'b0; redirect = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL redir_hs: got v=%b addr=%h expected v=0 addr=8", instr_valid, mem_addr);
    end
    run_fetch(32'h8, 32'h01020304);
  endtask

  task automatic test_fault();
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    n_checks++;
    if (fault !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h42) begin
      n_fail++;
      $display("FAIL fault_enter: got f=%b rd=%b v=%b addr=%h expected f=1 rd=0 v=0 addr=42",
               fault, mem_rd, instr_valid, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fault !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h42) begin
        n_fail++;
        $display("FAIL fault_sticky: got f=%b rd=%b addr=%h expected f=1 rd=0 addr=42", fault, mem_rd, mem_addr);
      end
    end
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h2000;
    tick();
    n_checks++;
    if (fault !== 1'b1 || mem_addr !== 32'h2000 || mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_range: got f=%b addr=%h rd=%b expected f=1 addr=2000 rd=0", fault, mem_addr, mem_rd);
    end
    redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || mem_addr !== 32'h8 || mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear: got f=%b addr=%h rd=%b expected f=0 addr=8 rd=1", fault, mem_addr, mem_rd);
    end
    run_fetch(32'h8, 32'h01020304);
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFC;
    tick();
    redirect = 1'b0;
    run_fetch(32'hFFC, 32'hCAFEBABE);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_checks++;
    if (mem_addr !== 32'h0 || fault !== 1'b0 || mem_rd !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: got addr=%h f=%b rd=%b v=%b expected addr=0 f=0 rd=1 v=0", mem_addr, fault, mem_rd, instr_valid);
    end
    run_fetch(32'h0, 32'h00A00513);
  endtask

  task automatic test_reset_in_hold();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd: got %b expected 0", mem_rd);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || fault !== 1'b0 || mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: got v=%b instr=%h pc=%h f=%b rd=%b expected all 0",
               instr_valid, instr, instr_pc, fault, mem_rd);
    end
    rst = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_addr !== 32'h0 || mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart: got addr=%h rd=%b expected addr=0 rd=1", mem_addr, mem_rd);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    run_fetch(32'h0, 32'h00A00513);
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0; instr_ready = 1'b1;
    exp_q.push_back(32'h00A00513);
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h01020304);
    #1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (instr_valid === 1'b1) begin
        logic [31:0] w;
        w = exp_q.pop_front();
        n_checks++;
        if (instr !== w || instr_pc !== 32'(4 * seen) || c != 4 + 5 * seen) begin
          n_fail++;
          $display("FAIL b2b: got instr=%h pc=%h cycle=%0d expected instr=%h pc=%h cycle=%0d",
                   instr, instr_pc, c, w, 32'(4 * seen), 4 + 5 * seen);
        end
        seen++;
      end
      tick();
    end
    instr_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d words left expected 0", exp_q.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}             = 32'h00A00513;
    {mem[4], mem[5], mem[6], mem[7]}             = 32'h11223344;
    {mem[8], mem[9], mem[10], mem[11]}           = 32'h01020304;
    {mem[64], mem[65], mem[66], mem[67]}         = 32'hDEADBEEF;
    {mem[4092], mem[4093], mem[4094], mem[4095]} = 32'hCAFEBABE;
    test_reset();
    test_hold_stall();
    test_redirect_partial();
    test_redirect_handshake();
    test_fault();
    test_wrap();
    test_reset_in_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
